// File: rtl/spi_reg_slave.sv
// spi_reg_slave -- SPI (mode 0) slave front end for the PWM IO expander.
//
// The SPI pins are oversampled in the MainCLK domain. Each frame starts with
// a command byte, followed by data bytes at auto-incrementing addresses:
//   command bit7 = 1 write / 0 read, bits[6:0] = register address.
// Writes become one-cycle strobes towards the register file. Reads are
// shifted out on MISO, MSB first.
//
// Ports:
//   MainCLK      system clock, rising edge
//   RST          asynchronous active-low reset
//   CS           SPI chip select, active low (asynchronous)
//   SCLK         SPI clock, CPOL=0/CPHA=0 (asynchronous)
//   MOSI         SPI data in, MSB first
//   MISO         SPI data out, MSB first; low outside the read phase
//   reg_wr_en    one-cycle write strobe
//   reg_addr     register address for writes and reads
//   reg_wr_data  write data, valid whenever reg_wr_en is high
//   reg_rd_data  register read data (combinational or 1-cycle registered)
//   busy         a frame is in progress
//   frame_err    sticky frame error, cleared at the next frame start
//   fsm_state    current FSM state (debug visibility)
//
// Write interface: reg_wr_en is a pure strobe with no back-pressure. The
// register file must accept reg_wr_data at reg_addr in every cycle where
// reg_wr_en is high. reg_addr steps to the next register in the cycle after
// the strobe.
module spi_reg_slave #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MainCLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  input  logic [7:0]        reg_rd_data,
  output logic              busy,
  output logic              frame_err,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_CMD       = 3'd2,
    S_WR_DATA   = 3'd3,
    S_RD_DATA   = 3'd4,
    S_IGNORE    = 3'd5
  } state_t;

  // The settle counter keeps WAIT_IDLE from trusting the synchroniser until
  // it has been refilled with real pin samples after reset. Without it, a CS
  // held low through reset would show up as a fresh cs_fall.
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] cs_pipe, sclk_pipe, mosi_pipe;
  logic                   cs_prev, sclk_prev;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   settled;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_shift;
  logic [1:0]  ld_cnt;
  logic        skip_fall;
  logic [1:0]  wr_pipe;

  // FSM decode strobes
  logic frame_start, frame_end, bit_take, cmd_bad, cmd_load;
  logic rd_reload, wr_done, tx_shift_en, rd_arm;

  // --------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // --------------------------------------------------------------------
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      cs_pipe   <= '1;
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], CS};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], SCLK};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  assign settled = (settle_cnt == SETTLE_MAX);

  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Byte as it will look once the current MOSI bit has been shifted in.
  assign rx_byte = {rx_shift[6:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_take    = 1'b0;
    cmd_bad     = 1'b0;
    cmd_load    = 1'b0;
    rd_reload   = 1'b0;
    wr_done     = 1'b0;
    tx_shift_en = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (settled && cs_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          state_d     = S_CMD;
        end
      end
      S_CMD, S_WR_DATA, S_RD_DATA: begin
        // cs_rise takes priority over a coinciding 8th SCLK rise, so such a
        // byte is dropped and reported through frame_err.
        if (cs_rise) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end else begin
          if (sclk_rise) begin
            bit_take = 1'b1;
            if (bit_cnt == 3'd7) begin
              if (state_q == S_CMD) begin
                if (rx_byte[6:ADDR_W] != '0) begin
                  cmd_bad = 1'b1;
                  state_d = S_IGNORE;
                end else begin
                  cmd_load = 1'b1;
                  state_d  = rx_byte[7] ? S_WR_DATA : S_RD_DATA;
                end
              end else if (state_q == S_WR_DATA) begin
                wr_done = 1'b1;
              end else begin
                rd_reload = 1'b1;
              end
            end
          end
          if (sclk_fall && (state_q == S_RD_DATA)) tx_shift_en = 1'b1;
        end
      end
      S_IGNORE: begin
        if (cs_rise) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // Each read byte (the first, right after the command, and each reload
  // after 8 bits) restarts the load countdown and skips one falling edge.
  assign rd_arm = (cmd_load && !rx_byte[7]) || rd_reload;

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------
  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      ld_cnt    <= '0;
      skip_fall <= 1'b0;
      frame_err <= 1'b0;
    end else if (frame_start) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      ld_cnt    <= '0;
      skip_fall <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (bit_take) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end
      // A partial byte at CS release is discarded and flagged.
      if ((frame_end && (bit_cnt != 3'd0)) || cmd_bad) frame_err <= 1'b1;

      // reg_rd_data is sampled two cycles after reg_addr changes. This
      // covers both a combinational and a registered register file.
      if (rd_arm) begin
        ld_cnt <= 2'd2;
      end else if (ld_cnt != 2'd0) begin
        ld_cnt <= ld_cnt - 2'd1;
      end

      // The falling edge that ends the last bit of a byte must not shift.
      // Otherwise it would shift away the MSB of the freshly loaded byte.
      if (rd_arm) begin
        skip_fall <= 1'b1;
      end else if (tx_shift_en) begin
        skip_fall <= 1'b0;
      end

      if (ld_cnt == 2'd1) begin
        tx_shift <= reg_rd_data;
      end else if (tx_shift_en && !skip_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // Write strobe pipeline. The data is captured on the 8th bit. The strobe
  // follows two cycles later, so reg_wr_en rises SYNC_STAGES+2 cycles after
  // the raw 8th SCLK rise is first sampled.
  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      wr_pipe     <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
    end else begin
      wr_pipe   <= {wr_pipe[0], wr_done};
      reg_wr_en <= wr_pipe[1];
      if (wr_done) reg_wr_data <= rx_byte;
    end
  end

  always_ff @(posedge MainCLK or negedge RST) begin
    if (!RST) begin
      reg_addr <= '0;
    end else if (cmd_load) begin
      reg_addr <= rx_byte[ADDR_W-1:0];
    end else if (rd_reload || reg_wr_en) begin
      reg_addr <= reg_addr + 1'b1;  // wraps naturally at 2^ADDR_W
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign MISO      = (state_q == S_RD_DATA) ? tx_shift[7] : 1'b0;
  assign busy      = (state_q != S_IDLE) && (state_q != S_WAIT_IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;
  localparam int ADDR_W      = 4;
  localparam int SYNC_STAGES = 3;
  localparam int HALF        = 6;                // MainCLK cycles per SCLK phase
  localparam int LAT_EXP     = SYNC_STAGES + 2;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;

  logic              MainCLK = 1'b0;
  logic              RST, CS, SCLK, MOSI;
  logic              MISO, reg_wr_en, busy, frame_err;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data, reg_rd_data;
  logic [2:0]        fsm_state;

  logic [7:0]        regs [2**ADDR_W];
  logic [ADDR_W+7:0] exp_q[$];   // expected {addr, data} writes
  logic [ADDR_W+7:0] got_q[$];   // observed {addr, data} writes
  logic [7:0]        rd_exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  spi_reg_slave #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .MainCLK(MainCLK), .RST(RST), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .busy(busy),
    .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // ---------------- clock / register model / write monitor ----------------
  always #5 MainCLK = ~MainCLK;

  assign reg_rd_data = regs[reg_addr];

  always @(negedge MainCLK) begin
    if (RST === 1'b1 && reg_wr_en === 1'b1) begin
      got_q.push_back({reg_addr, reg_wr_data});
      regs[reg_addr] <= reg_wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge MainCLK);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    CS = 1'b1;
    wait_clks(3 * HALF);
  endtask

  // Shifts nbits of tx (from the MSB down) and returns the MISO bits that a
  // mode-0 master samples just before each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      MOSI = tx[i];
      wait_clks(HALF);
      rx = {rx[6:0], MISO};
      SCLK = 1'b1;
      wait_clks(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wait_clks(3);
    vectors++; if (MISO !== 1'b0) begin miscompares++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    vectors++; if (reg_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got=%b exp=0", reg_wr_en); end
    vectors++; if (reg_addr !== '0) begin miscompares++; $display("FAIL reset_addr got=%h exp=0", reg_addr); end
    vectors++; if (reg_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data got=%h exp=00", reg_wr_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    vectors++; if (fsm_state !== ST_WAIT_IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, ST_WAIT_IDLE); end
    RST = 1'b1;
    wait_clks(4 * SYNC_STAGES);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_burst();
    logic [7:0] rx;
    logic [ADDR_W+7:0] e, g;
    push_wr(4'd3, 8'h40);
    push_wr(4'd4, 8'h7F);
    cs_low();
    spi_bits(8'h83, 8, rx);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL burst_busy_mid got=%b exp=1", busy); end
    spi_bits(8'h40, 8, rx);
    vectors++; if (MISO !== 1'b0) begin miscompares++; $display("FAIL burst_miso got=%b exp=0", MISO); end
    spi_bits(8'h7F, 8, rx);
    cs_high();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL burst_busy_end got=%b exp=0", busy); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL burst_frame_err got=%b exp=0", frame_err); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL burst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL burst_write got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    logic [ADDR_W+7:0] e, g;
    push_wr(4'd15, 8'h11);
    push_wr(4'd0, 8'h22);
    cs_low();
    spi_bits(8'h8F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_high();
    vectors++; if (reg_addr !== 4'd1) begin miscompares++; $display("FAIL wrap_addr_after got=%h exp=1", reg_addr); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL wrap_write got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_readback();
    logic [7:0] rx, e;
    regs[5] = 8'hA5;
    regs[6] = 8'h3C;
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h3C);
    cs_low();
    spi_bits(8'h05, 8, rx);
    for (int b = 0; b < 2; b++) begin
      spi_bits(8'h00, 8, rx);
      e = rd_exp_q.pop_front();
      vectors++; if (rx !== e) begin miscompares++; $display("FAIL read_byte%0d got=%h exp=%h", b, rx, e); end
    end
    cs_high();
    vectors++; if (MISO !== 1'b0) begin miscompares++; $display("FAIL read_miso_idle got=%b exp=0", MISO); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL read_frame_err got=%b exp=0", frame_err); end
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL read_no_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    cs_low();
    spi_bits(8'h90, 8, rx);
    wait_clks(HALF);
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL badcmd_err got=%b exp=1", frame_err); end
    spi_bits(8'h55, 8, rx);
    vectors++; if (MISO !== 1'b0) begin miscompares++; $display("FAIL badcmd_miso got=%b exp=0", MISO); end
    cs_high();
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL badcmd_sticky got=%b exp=1", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badcmd_busy got=%b exp=0", busy); end
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL badcmd_no_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_partial_byte();
    logic [7:0] rx;
    logic [ADDR_W+7:0] e, g;
    cs_low();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_high();
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL partial_err got=%b exp=1", frame_err); end
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL partial_no_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
    cs_low();
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL partial_err_clear got=%b exp=0", frame_err); end
    push_wr(4'd1, 8'h99);
    spi_bits(8'h81, 8, rx);
    spi_bits(8'h99, 8, rx);
    cs_high();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL partial_next_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL partial_next_write got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rx;
    logic [ADDR_W+7:0] e, g;
    cs_low();
    spi_bits(8'h87, 8, rx);
    spi_bits(8'hFF, 3, rx);
    RST = 1'b0;
    wait_clks(2);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vectors++; if (reg_addr !== '0) begin miscompares++; $display("FAIL rstmid_addr got=%h exp=0", reg_addr); end
    vectors++; if (fsm_state !== ST_WAIT_IDLE) begin miscompares++; $display("FAIL rstmid_state got=%0d exp=%0d", fsm_state, ST_WAIT_IDLE); end
    RST = 1'b1;
    wait_clks(2 * SYNC_STAGES);
    spi_bits(8'hAA, 8, rx);
    wait_clks(HALF);
    vectors++; if (fsm_state !== ST_WAIT_IDLE) begin miscompares++; $display("FAIL rstmid_wait got=%0d exp=%0d", fsm_state, ST_WAIT_IDLE); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_frame got=%b exp=0", busy); end
    cs_high();
    vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL rstmid_no_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
    push_wr(4'd2, 8'h55);
    cs_low();
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h55, 8, rx);
    cs_high();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rstmid_next_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL rstmid_next_write got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_latency();
    logic [7:0] rx;
    logic [ADDR_W+7:0] e, g;
    int lat;
    bit seen;
    push_wr(4'hA, 8'h5C);
    cs_low();
    spi_bits(8'h8A, 8, rx);
    spi_bits(8'h5C, 7, rx);
    MOSI = 1'b0;                 // bit0 of 0x5C
    wait_clks(HALF);
    SCLK = 1'b1;                 // first sampled by the next rising edge
    @(posedge MainCLK);
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge MainCLK);
      #1;
      if (reg_wr_en === 1'b1) begin seen = 1'b1; lat = k; end
    end
    vectors++; if (lat != LAT_EXP) begin miscompares++; $display("FAIL latency got=%0d exp=%0d", lat, LAT_EXP); end
    wait_clks(HALF);
    SCLK = 1'b0;
    cs_high();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL latency_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL latency_write got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx, d;
    logic [ADDR_W-1:0] start, a;
    logic [ADDR_W+7:0] e, g;
    for (int f = 0; f < 3; f++) begin
      start = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      cs_low();
      spi_bits({1'b1, 3'b000, start}, 8, rx);
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        a = start + ADDR_W'(i);
        push_wr(a, d);
        spi_bits(d, 8, rx);
      end
      wait_clks(HALF);
      CS = 1'b1;
      wait_clks(HALF);           // short gap before the next frame
    end
    wait_clks(2 * HALF);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin miscompares++; $display("FAIL b2b_write got=%h exp=%h", g, e); end
    end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL b2b_frame_err got=%b exp=0", frame_err); end
    exp_q.delete(); got_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) regs[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_wrap();
    test_readback();
    test_bad_cmd();
    test_partial_byte();
    test_reset_mid_frame();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
